// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared encodings for the two-master Wishbone arbiter
//
// Purpose: arbiter state encoding, master index constants and a grant decode
// helper, imported by wb_rr_arbiter and available to the bridge.
// Ports: none (package).
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no owner
    OWN   = 2'd1,  // owner register valid, forwarding
    DRAIN = 2'd2,  // owner blocked, collecting outstanding acks
    GAP   = 2'd3   // one cycle with s_cyc_o low between owners
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  function automatic logic [1:0] grant_onehot(input logic idx);
    return (idx == M1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/wb_txn_counter.sv
// rtl/wb_txn_counter.sv - outstanding-request counter with inc/dec/clear and full flag
//
// Purpose: counts accepted-but-unanswered Wishbone requests.
// Ports:
//   clk_i    in   system clock
//   reset_i  in   synchronous active-high reset
//   clear_i  in   drop all outstanding requests (abort)
//   inc_i    in   a request was accepted this cycle
//   dec_i    in   a request completed (ack or err) this cycle
//   count_o  out  current outstanding count
//   full_o   out  count has reached MAX_COUNT
module wb_txn_counter #(
  parameter int MAX_COUNT = 16,
  localparam int CW       = $clog2(MAX_COUNT) + 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clear_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o,
  output logic          full_o
);

  assign full_o = (count_o == CW'(MAX_COUNT));

  // Simultaneous inc and dec leave the count unchanged; both directions
  // saturate so a stray pulse can never wrap the counter.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      count_o <= '0;
    end else if (inc_i && !dec_i && !full_o) begin
      count_o <= count_o + CW'(1);
    end else if (dec_i && !inc_i && (count_o != '0)) begin
      count_o <= count_o - CW'(1);
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - two-master round-robin pipelined Wishbone arbiter
//
// Purpose: shares one pipelined Wishbone slave between the QSPI bridge (m0)
// and a second requester (m1). Ownership is per bus cycle, alternating on
// ties; a strobe budget forces the owner to yield to a waiting master, and
// an outstanding counter steers every ack/err back to the issuing master.
// Ports:
//   clk_i, reset_i                  clock, synchronous active-high reset
//   mX_cyc_i/stb_i/we_i/adr_i/dat_i master X request
//   mX_ack_o/err_o/stall_o/dat_o    master X response
//   s_cyc_o/stb_o/we_o/adr_o/dat_o  slave request
//   s_ack_i/err_i/stall_i/dat_i     slave response
//   grant_o                         one-hot current owner, 00 when none
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDRBITS        = 26,
  parameter int DATABITS        = 16,
  parameter int MAX_OUTSTANDING = 16,
  parameter int BURST_LIMIT     = 32
) (
  input  logic                clk_i,
  input  logic                reset_i,

  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [ADDRBITS-1:0] m0_adr_i,
  input  logic [DATABITS-1:0] m0_dat_i,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  output logic                m0_stall_o,
  output logic [DATABITS-1:0] m0_dat_o,

  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [ADDRBITS-1:0] m1_adr_i,
  input  logic [DATABITS-1:0] m1_dat_i,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic                m1_stall_o,
  output logic [DATABITS-1:0] m1_dat_o,

  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [ADDRBITS-1:0] s_adr_o,
  output logic [DATABITS-1:0] s_dat_o,
  input  logic                s_ack_i,
  input  logic                s_err_i,
  input  logic                s_stall_i,
  input  logic [DATABITS-1:0] s_dat_i,

  output logic [1:0]          grant_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int BW = $clog2(BURST_LIMIT) + 1;

  arb_state_t    state;
  logic          owner;
  logic          last_owner;
  logic [BW-1:0] budget;
  logic [1:0]    grant_q;

  logic                o_cyc, o_stb, o_we, other_cyc;
  logic [ADDRBITS-1:0] o_adr;
  logic [DATABITS-1:0] o_dat;

  logic [CW-1:0] outstanding;
  logic          full;
  logic          on_bus, preempt, accept, resp_ok, route_ack, route_err;
  logic          done, drop, owner_open, pick;

  wb_txn_counter #(
    .MAX_COUNT (MAX_OUTSTANDING)
  ) u_txn_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (drop),
    .inc_i   (accept),
    .dec_i   (done),
    .count_o (outstanding),
    .full_o  (full)
  );

  // Owner-side request mux.
  always_comb begin
    o_cyc     = (owner == M1) ? m1_cyc_i : m0_cyc_i;
    o_stb     = (owner == M1) ? m1_stb_i : m0_stb_i;
    o_we      = (owner == M1) ? m1_we_i  : m0_we_i;
    o_adr     = (owner == M1) ? m1_adr_i : m0_adr_i;
    o_dat     = (owner == M1) ? m1_dat_i : m0_dat_i;
    other_cyc = (owner == M1) ? m0_cyc_i : m1_cyc_i;
  end

  assign on_bus  = (state == OWN) || (state == DRAIN);
  // The strobe is masked in the very cycle the budget runs out with the
  // other master waiting, so the owner never gets more than BURST_LIMIT.
  assign preempt = (state == OWN) && (budget == '0) && other_cyc;

  assign s_cyc_o = on_bus && o_cyc;
  assign s_stb_o = (state == OWN) && o_cyc && o_stb && !full && !preempt;
  assign s_we_o  = o_we;
  assign s_adr_o = o_adr;
  assign s_dat_o = o_dat;

  assign accept = s_stb_o && !s_stall_i;
  // Responses are only meaningful while the owner still holds its cycle and
  // something is (or is just becoming) outstanding; anything else is stale.
  assign resp_ok   = on_bus && o_cyc && ((outstanding != '0) || accept);
  assign route_ack = resp_ok && s_ack_i;
  assign route_err = resp_ok && s_err_i;
  assign done      = route_ack || route_err;
  assign drop      = on_bus && !o_cyc;

  assign owner_open = (state == OWN) && !preempt && !full && !s_stall_i;
  assign m0_stall_o = !(owner_open && (owner == M0));
  assign m1_stall_o = !(owner_open && (owner == M1));
  assign m0_ack_o   = route_ack && (owner == M0);
  assign m1_ack_o   = route_ack && (owner == M1);
  assign m0_err_o   = route_err && (owner == M0);
  assign m1_err_o   = route_err && (owner == M1);
  assign m0_dat_o   = s_dat_i;
  assign m1_dat_o   = s_dat_i;
  assign grant_o    = grant_q;

  // Tie-break: the master that did not own the bus last time wins.
  assign pick = (m0_cyc_i && m1_cyc_i) ? ~last_owner : m1_cyc_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= IDLE;
      owner      <= M0;
      last_owner <= M1;
      budget     <= '0;
      grant_q    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cyc_i || m1_cyc_i) begin
            owner   <= pick;
            state   <= OWN;
            budget  <= BW'(BURST_LIMIT);
            grant_q <= grant_onehot(pick);
          end
        end
        OWN: begin
          if (!o_cyc) begin
            state      <= IDLE;
            last_owner <= owner;
            grant_q    <= 2'b00;
          end else begin
            if (accept && (budget != '0)) begin
              budget <= budget - BW'(1);
            end
            if (preempt) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!o_cyc) begin
            state      <= IDLE;
            last_owner <= owner;
            grant_q    <= 2'b00;
          end else if (!other_cyc) begin
            // Waiting master gave up; the owner simply carries on.
            state <= OWN;
          end else if (outstanding == '0) begin
            state      <= GAP;
            last_owner <= owner;
            grant_q    <= 2'b00;
          end
        end
        GAP: begin
          if (other_cyc) begin
            owner   <= ~owner;
            state   <= OWN;
            budget  <= BW'(BURST_LIMIT);
            grant_q <= grant_onehot(~owner);
          end else if (o_cyc) begin
            state   <= OWN;
            budget  <= BW'(BURST_LIMIT);
            grant_q <= grant_onehot(owner);
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule
